// File: rtl/hub75_rx_if.sv
// HUB75 panel inputs and frame-buffer pixel write port for hub75_rx.
// The slave modport is the receiver; master is the panel source / frame-buffer side.
interface hub75_rx_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned COL_WIDTH  = 6
);
  logic                  hub_clk;
  logic                  hub_lat;
  logic                  hub_oe;
  logic [ADDR_WIDTH-1:0] hub_addr;
  logic [2:0]            hub_rgb0;
  logic [2:0]            hub_rgb1;

  logic                  pix_we;
  logic [ADDR_WIDTH-1:0] pix_row;
  logic [COL_WIDTH-1:0]  pix_col;
  logic [5:0]            pix_data;

  modport master (
    output hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb0, hub_rgb1,
    input  pix_we, pix_row, pix_col, pix_data
  );

  modport slave (
    input  hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb0, hub_rgb1,
    output pix_we, pix_row, pix_col, pix_data
  );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receiver: synchronises the panel bus, rebuilds each shifted row and
// replays it into a frame-buffer write port after every latch.
module hub75_rx #(
  parameter int unsigned PIXEL_COLUMNS = 32,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned COL_WIDTH     = 6,
  parameter int unsigned OE_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  hub75_rx_if.slave               bus,
  output logic                    line_done,
  output logic [COL_WIDTH:0]      line_cols,
  output logic [OE_CNT_WIDTH-1:0] oe_low_cycles,
  output logic                    err_ovf,
  output logic                    err_busy
);

  localparam int unsigned IDX_W = $clog2(PIXEL_COLUMNS);
  localparam logic [COL_WIDTH:0] CNT_MAX = (COL_WIDTH+1)'(PIXEL_COLUMNS);
  localparam logic [COL_WIDTH:0] CNT_SAT = (COL_WIDTH+1)'(PIXEL_COLUMNS + 1);

  typedef enum logic {SHIFT, COMMIT} state_t;

  state_t r_state, w_next_state;

  logic [2:0]              r_clk_sync, r_lat_sync;
  logic [1:0]              r_oe_sync;
  logic [ADDR_WIDTH-1:0]   r_addr_s1, r_addr_s2, r_addr_s3;
  logic [5:0]              r_rgb_s1, r_rgb_s2, r_rgb_s3;

  logic [COL_WIDTH:0]      r_col_cnt, r_ptr, r_line_cols;
  logic [OE_CNT_WIDTH-1:0] r_oe_cnt, r_oe_low;
  logic [ADDR_WIDTH-1:0]   r_row;
  logic                    r_err_ovf, r_err_busy;
  logic [5:0]              r_line_buf [PIXEL_COLUMNS];

  logic                    w_clk_edge, w_lat_edge;
  logic [COL_WIDTH:0]      w_col_next, w_n_commit;
  logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_lat_sync <= '0;
      r_oe_sync  <= '0;
      r_addr_s1  <= '0;
      r_addr_s2  <= '0;
      r_addr_s3  <= '0;
      r_rgb_s1   <= '0;
      r_rgb_s2   <= '0;
      r_rgb_s3   <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], bus.hub_clk};
      r_lat_sync <= {r_lat_sync[1:0], bus.hub_lat};
      r_oe_sync  <= {r_oe_sync[0], bus.hub_oe};
      r_addr_s1  <= bus.hub_addr;
      r_addr_s2  <= r_addr_s1;
      r_addr_s3  <= r_addr_s2;
      r_rgb_s1   <= {bus.hub_rgb1, bus.hub_rgb0};
      r_rgb_s2   <= r_rgb_s1;
      r_rgb_s3   <= r_rgb_s2;
    end
  end

  // s3 data is aligned with the pre-edge clock level, so it holds the value
  // present just before the rising edge.
  assign w_clk_edge = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_lat_edge = r_lat_sync[1] & ~r_lat_sync[2];
  assign w_col_next = (w_clk_edge && r_col_cnt < CNT_SAT) ? r_col_cnt + 1'b1 : r_col_cnt;
  assign w_n_commit = (r_line_cols > CNT_MAX) ? CNT_MAX : r_line_cols;
  assign w_wr_idx   = r_col_cnt[IDX_W-1:0];
  assign w_rd_idx   = r_ptr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (w_clk_edge && r_col_cnt < CNT_MAX) begin
      r_line_buf[w_wr_idx] <= r_rgb_s3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SHIFT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SHIFT:   if (w_lat_edge) w_next_state = COMMIT;
      COMMIT:  if (r_ptr == w_n_commit) w_next_state = SHIFT;
      default: w_next_state = SHIFT;
    endcase
  end

  always_comb begin
    bus.pix_we   = 1'b0;
    bus.pix_col  = '0;
    bus.pix_data = '0;
    line_done    = 1'b0;
    if (r_state == COMMIT) begin
      if (r_ptr < w_n_commit) begin
        bus.pix_we   = 1'b1;
        bus.pix_col  = r_ptr[COL_WIDTH-1:0];
        bus.pix_data = r_line_buf[w_rd_idx];
      end else begin
        line_done = 1'b1;
      end
    end
  end

  // Column counting continues during COMMIT so the next line can fill the
  // buffer behind the commit pointer; a same-cycle clock edge joins the latched line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_cnt   <= '0;
      r_oe_cnt    <= '0;
      r_oe_low    <= '0;
      r_line_cols <= '0;
      r_row       <= '0;
      r_ptr       <= '0;
      r_err_ovf   <= 1'b0;
      r_err_busy  <= 1'b0;
    end else begin
      r_col_cnt <= w_col_next;
      if (w_clk_edge && r_col_cnt >= CNT_MAX) r_err_ovf <= 1'b1;
      if (!r_oe_sync[1] && r_oe_cnt != '1) r_oe_cnt <= r_oe_cnt + 1'b1;
      if (r_state == SHIFT && w_lat_edge) begin
        r_row       <= r_addr_s3;
        r_line_cols <= w_col_next;
        r_oe_low    <= r_oe_cnt;
        r_col_cnt   <= '0;
        r_oe_cnt    <= '0;
        r_ptr       <= '0;
      end
      if (r_state == COMMIT) begin
        if (w_lat_edge) r_err_busy <= 1'b1;
        if (r_ptr < w_n_commit) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign bus.pix_row   = r_row;
  assign line_cols     = r_line_cols;
  assign oe_low_cycles = r_oe_low;
  assign err_ovf       = r_err_ovf;
  assign err_busy      = r_err_busy;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed and randomised bench for hub75_rx against a queue-based line model.
module tb_hub75_rx;
  localparam int unsigned P  = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 6;
  localparam int unsigned OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          line_done;
  logic [CW:0]   line_cols;
  logic [OW-1:0] oe_low_cycles;
  logic          err_ovf, err_busy;

  hub75_rx_if #(.ADDR_WIDTH(AW), .COL_WIDTH(CW)) bus ();

  hub75_rx #(
    .PIXEL_COLUMNS(P),
    .ADDR_WIDTH(AW),
    .COL_WIDTH(CW),
    .OE_CNT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .line_done(line_done),
    .line_cols(line_cols),
    .oe_low_cycles(oe_low_cycles),
    .err_ovf(err_ovf),
    .err_busy(err_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] mon_q[$];
  int          done_cnt = 0;
  logic [CW:0] last_cols = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pix_we) mon_q.push_back({bus.pix_row, bus.pix_col, bus.pix_data});
      if (line_done) begin
        done_cnt++;
        last_cols = line_cols;
      end
    end
  end

  logic [5:0] mdl_line[$];
  int         mdl_edges = 0;
  bit         mdl_ovf = 0;
  bit         mdl_busy = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hub_edge(input logic [2:0] r0, input logic [2:0] r1, input bit toggle);
    bus.hub_rgb0 = r0;
    bus.hub_rgb1 = r1;
    ticks(3);
    bus.hub_clk = 1'b1;
    if (toggle) begin
      bus.hub_rgb0 = ~r0;
      bus.hub_rgb1 = ~r1;
    end
    if (mdl_edges < int'(P)) mdl_line.push_back({r1, r0});
    else mdl_ovf = 1;
    mdl_edges++;
    ticks(4);
    bus.hub_clk = 1'b0;
    ticks(3);
  endtask

  task automatic rand_edges(input int n);
    for (int i = 0; i < n; i++) hub_edge(3'($urandom), 3'($urandom), 1'b0);
  endtask

  task automatic commit_line(input string tag, input logic [AW-1:0] addr, input bit double_latch);
    int base, dbase, nexp, cols_exp;
    logic [14:0] exp_px;
    base  = mon_q.size();
    dbase = done_cnt;
    bus.hub_addr = addr;
    ticks(3);
    bus.hub_lat = 1'b1;
    if (double_latch) begin
      ticks(2); bus.hub_lat = 1'b0;
      ticks(3); bus.hub_lat = 1'b1;
      ticks(2); bus.hub_lat = 1'b0;
      mdl_busy = 1;
    end else begin
      ticks(4); bus.hub_lat = 1'b0;
    end
    for (int i = 0; i < 200 && done_cnt == dbase; i++) ticks(1);
    if (double_latch) ticks(60);
    chk({tag, ".line_done_count"}, 32'(done_cnt - dbase), 32'd1);
    nexp     = imin(mdl_edges, int'(P));
    cols_exp = imin(mdl_edges, int'(P) + 1);
    chk({tag, ".write_count"}, 32'(mon_q.size() - base), 32'(nexp));
    for (int k = 0; k < nexp; k++) begin
      if (base + k < mon_q.size()) begin
        exp_px = {addr, 6'(k), mdl_line[k]};
        chk($sformatf("%s.pix[%0d]", tag, k), 32'(mon_q[base + k]), 32'(exp_px));
      end
    end
    chk({tag, ".line_cols"}, 32'(last_cols), 32'(cols_exp));
    chk({tag, ".err_ovf"}, 32'(err_ovf), 32'(mdl_ovf));
    chk({tag, ".err_busy"}, 32'(err_busy), 32'(mdl_busy));
    mdl_line.delete();
    mdl_edges = 0;
  endtask

  initial begin
    int dbase, base, n;
    bit seen;
    bus.hub_clk  = 1'b0;
    bus.hub_lat  = 1'b0;
    bus.hub_oe   = 1'b1;
    bus.hub_addr = '0;
    bus.hub_rgb0 = '0;
    bus.hub_rgb1 = '0;
    ticks(3);
    chk("rst.pix_we", 32'(bus.pix_we), 32'd0);
    chk("rst.pix_row", 32'(bus.pix_row), 32'd0);
    chk("rst.pix_col", 32'(bus.pix_col), 32'd0);
    chk("rst.pix_data", 32'(bus.pix_data), 32'd0);
    chk("rst.line_done", 32'(line_done), 32'd0);
    chk("rst.line_cols", 32'(line_cols), 32'd0);
    chk("rst.oe_low", 32'(oe_low_cycles), 32'd0);
    chk("rst.flags", 32'({err_ovf, err_busy}), 32'd0);
    rst = 1'b0;
    ticks(3);

    for (int k = 0; k < 32; k++) hub_edge((k == 5) ? 3'b111 : 3'b100, 3'b001, 1'b0);
    commit_line("full", 3'd3, 1'b0);

    for (int k = 0; k < 32; k++) hub_edge(3'($urandom), 3'($urandom), 1'b1);
    commit_line("toggle", AW'($urandom), 1'b0);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 32);
      rand_edges(n);
      commit_line($sformatf("rand%0d", r), AW'($urandom), 1'b0);
    end

    // Empty line: detection is two clk after the latch is driven, line_done one clk later
    dbase = done_cnt;
    base  = mon_q.size();
    bus.hub_addr = 3'd6;
    ticks(3);
    bus.hub_lat = 1'b1;
    ticks(2);
    chk("empty.done_early", 32'(line_done), 32'd0);
    ticks(1);
    chk("empty.done_time", 32'(line_done), 32'd1);
    chk("empty.no_we", 32'(bus.pix_we), 32'd0);
    ticks(3);
    bus.hub_lat = 1'b0;
    ticks(5);
    chk("empty.done_count", 32'(done_cnt - dbase), 32'd1);
    chk("empty.writes", 32'(mon_q.size() - base), 32'd0);
    chk("empty.line_cols", 32'(last_cols), 32'd0);

    ticks(4);
    bus.hub_oe = 1'b0;
    ticks(10);
    bus.hub_oe = 1'b1;
    ticks(5);
    commit_line("oe", 3'd1, 1'b0);
    chk("oe.low_cycles", 32'(oe_low_cycles), 32'd10);

    rand_edges(35);
    commit_line("ovf", 3'd2, 1'b0);

    rand_edges(8);
    commit_line("busy", 3'd5, 1'b1);

    rand_edges(20);
    bus.hub_addr = 3'd4;
    ticks(3);
    bus.hub_lat = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      ticks(1);
      seen = bus.pix_we;
    end
    chk("rstmid.commit_started", 32'(seen), 32'd1);
    ticks(3);
    rst = 1'b1;
    bus.hub_lat = 1'b0;
    ticks(1);
    chk("rstmid.pix_we", 32'(bus.pix_we), 32'd0);
    chk("rstmid.line_done", 32'(line_done), 32'd0);
    chk("rstmid.err_ovf", 32'(err_ovf), 32'd0);
    chk("rstmid.err_busy", 32'(err_busy), 32'd0);
    chk("rstmid.line_cols", 32'(line_cols), 32'd0);
    chk("rstmid.oe_low", 32'(oe_low_cycles), 32'd0);
    chk("rstmid.pix_row", 32'(bus.pix_row), 32'd0);
    ticks(1);
    rst = 1'b0;
    mdl_line.delete();
    mdl_edges = 0;
    mdl_ovf   = 0;
    mdl_busy  = 0;
    ticks(3);

    rand_edges(12);
    commit_line("after_rst", 3'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- HUB75 receive end. Samples the HUB75 panel interface produced by our matrix driver, rebuilds each shifted row, and writes it pixel by pixel into a frame-buffer write port.
- Serves as the on-board loopback checker and panel emulator for the GLM matrix driver.
- All HUB75 inputs are asynchronous to clk and are synchronised inside the block.

Parameters:
- PIXEL_COLUMNS, 32, pixels per shifted row (max columns buffered per latch)
- ADDR_WIDTH, 3, width of the row-address bus (A/B/C)
- COL_WIDTH, 6, width of the column index; must satisfy 2**COL_WIDTH > PIXEL_COLUMNS
- OE_CNT_WIDTH, 16, width of the OE-low cycle counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- hub_clk  in  1  HUB75 shift clock (async)
- hub_lat  in  1  HUB75 latch (async)
- hub_oe  in  1  HUB75 output enable, active-low (async)
- hub_addr  in  ADDR_WIDTH  row address A/B/C (async)
- hub_rgb0  in  3  upper-half pixel data (async)
- hub_rgb1  in  3  lower-half pixel data (async)
- pix_we  out  1  frame-buffer write strobe, one clk per pixel
- pix_row  out  ADDR_WIDTH  row address of the pixel written
- pix_col  out  COL_WIDTH  column index of the pixel written
- pix_data  out  6  {rgb1, rgb0}
- line_done  out  1  one-clk pulse after the last pixel of a line is written
- line_cols  out  COL_WIDTH+1  hub_clk rising edges counted in the committed line
- oe_low_cycles  out  OE_CNT_WIDTH  clk cycles hub_oe was low during the previous latch period
- err_ovf  out  1  sticky: a line had more than PIXEL_COLUMNS clocks
- err_busy  out  1  sticky: a latch arrived while a commit was in progress

Behaviour:
- Synchronisation
  - Every hub_* input passes a 2-flop synchroniser.
  - Rising edges of hub_clk and hub_lat are detected from a third registered stage: edge = s2 & ~s3.
- Data sampling
  - On a hub_clk edge, capture the rgb/addr value held in the s3 stage, i.e. the value just before the edge.
  - This tolerates a source that changes data coincident with its clock edge.
- Shift state (SHIFT)
  - Each hub_clk edge writes {rgb1, rgb0} to line_buf[col_cnt] while col_cnt < PIXEL_COLUMNS.
  - col_cnt increments on every edge and saturates at PIXEL_COLUMNS+1.
  - Any edge arriving with col_cnt >= PIXEL_COLUMNS discards its data and sets err_ovf.
- Latch handling in SHIFT
  - A hub_lat edge captures row = synchronised addr, line_cols = min(col_cnt, PIXEL_COLUMNS+1), and oe_low_cycles = oe_cnt.
  - It then clears col_cnt and oe_cnt and moves to COMMIT.
  - If col_cnt == 0 the block still enters COMMIT, writes nothing, and pulses line_done.
  - A hub_clk edge in the same cycle as a hub_lat edge is counted into the line being latched, before the clear.
- COMMIT state
  - For k = 0 .. min(line_cols, PIXEL_COLUMNS)-1, one pixel per clk: pix_we=1, pix_col=k, pix_row=row, pix_data=line_buf[k].
  - The clk after the last write: line_done=1 for one cycle, return to SHIFT.
  - Worst-case latency from latch edge to line_done is PIXEL_COLUMNS+1 clk.
- Events during COMMIT
  - hub_clk edges keep filling line_buf for the next line. This is safe because the commit pointer always leads, given that source clocks are far slower than clk.
  - A hub_lat edge during COMMIT sets err_busy. That latch is ignored; the current commit finishes unchanged.
- OE counter
  - oe_cnt increments each clk while synchronised hub_oe == 0 and saturates at all-ones.
- Reset
  - Outputs: pix_we=0, pix_row=0, pix_col=0, pix_data=0, line_done=0, line_cols=0, oe_low_cycles=0, err_ovf=0, err_busy=0.
  - State = SHIFT, col_cnt=0, oe_cnt=0; synchroniser stages cleared to 0.
  - Reset mid-COMMIT aborts the commit immediately with no further pix_we.
  - line_buf contents need not be reset.
- The error flags are cleared only by rst.

Test Plan:
- Shift 32 pixels, pixel 5 = rgb0 3'b111, all others rgb0 3'b100, rgb1 3'b001 on every pixel; latch with addr=3:
  - 32 pix_we, pix_row=3, pix_col 0..31.
  - pix_data at col 5 = 6'b001111; every other col = 6'b001100.
  - line_cols=32, then line_done.
- Data toggling in the same clk as the hub_clk rising edge: captured values equal the pre-edge values at every column.
- 35 hub_clk edges, then latch: err_ovf=1, exactly 32 writes, line_cols=33.
- Latch with no preceding hub_clk: zero pix_we; line_done 1 clk after the latch edge is detected; line_cols=0.
- hub_oe low for exactly 10 clk between two latches: oe_low_cycles=10 after the second latch.
- Second latch issued 5 clk after the first: err_busy=1, only the first line is written; assert rst during a commit: pix_we drops the next cycle and all flags read 0.
